// File: rtl/malha_pkg.sv
// Shared definitions for the occupancy grid writer, the `distancias` search
// and the bench.
//   celula_t : 2-bit cell contents
//   estado_t : writer FSM states
//   indice   : linear cell index x + y*tam
package malha_pkg;

  typedef enum logic [1:0] {
    LIVRE     = 2'b00,
    OBSTACULO = 2'b01,
    VISITADO  = 2'b10,
    INTERESSE = 2'b11
  } celula_t;

  typedef enum logic [1:0] {
    OCIOSO,
    LIMPANDO,
    DISPARO,
    AGUARDA
  } estado_t;

  function automatic int unsigned indice(input int unsigned x,
                                         input int unsigned y,
                                         input int unsigned tam);
    return x + y * tam;
  endfunction

endpackage

// File: rtl/atualizador_malha.sv
// Occupancy grid writer. Accepts cell updates over valid/ready, keeps the
// grid in registers, and hands a frozen grid plus robot position to
// `distancias` with a one-cycle novoDado pulse when a batch closes.
// Ports:
//   clock, reset (async, active low)
//   escritaValida/escritaPronta, escritaX/Y, escritaCelula, fimLote : update port
//   posicaoX/Y           : robot position, captured on an accepted fimLote
//   limparMalha          : level request to clear the whole grid (one row/cycle)
//   malha                : grid, cell index x + y*TamanhoMalha
//   posicaoAtualnoEixoX/Y: captured position
//   novoDado             : start pulse to `distancias`
//   operacaoFinalizada   : done flag from `distancias` (rising edge completes)
//   ocupado, erroTimeout, descartes : status
module atualizador_malha
  import malha_pkg::*;
#(
  parameter int TamanhoMalha     = 8,
  parameter int tamanhoDistancia = 8,
  parameter int TimeoutCiclos    = 1024
) (
  input  logic                                            clock,
  input  logic                                            reset,
  input  logic                                            escritaValida,
  output logic                                            escritaPronta,
  input  logic [tamanhoDistancia-1:0]                     escritaX,
  input  logic [tamanhoDistancia-1:0]                     escritaY,
  input  celula_t                                         escritaCelula,
  input  logic                                            fimLote,
  input  logic [tamanhoDistancia-1:0]                     posicaoX,
  input  logic [tamanhoDistancia-1:0]                     posicaoY,
  input  logic                                            limparMalha,
  output logic [TamanhoMalha*TamanhoMalha-1:0][1:0]       malha,
  output logic [tamanhoDistancia-1:0]                     posicaoAtualnoEixoX,
  output logic [tamanhoDistancia-1:0]                     posicaoAtualnoEixoY,
  output logic                                            novoDado,
  input  logic                                            operacaoFinalizada,
  output logic                                            ocupado,
  output logic                                            erroTimeout,
  output logic [7:0]                                      descartes
);

  localparam int NC = TamanhoMalha * TamanhoMalha;
  localparam int IW = (NC > 1) ? $clog2(NC) : 1;
  localparam int LW = (TamanhoMalha > 1) ? $clog2(TamanhoMalha) : 1;
  localparam int TW = $clog2(TimeoutCiclos) + 1;

  estado_t                     estado_q, estado_d;
  logic [NC-1:0][1:0]          malha_q, malha_d;
  logic [tamanhoDistancia-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [LW-1:0]               linha_q, linha_d;
  logic [TW-1:0]               tmr_q, tmr_d;
  logic                        erro_q, erro_d;
  logic [7:0]                  desc_q, desc_d;
  logic                        fin_prev_q, fin_prev_d;

  logic          transfer, in_range, borda, estouro, fim_linha;
  logic [IW-1:0] idx, base;

  assign transfer  = escritaValida && escritaPronta;
  assign in_range  = (escritaX < tamanhoDistancia'(TamanhoMalha)) &&
                     (escritaY < tamanhoDistancia'(TamanhoMalha));
  assign idx       = IW'(escritaX) + IW'(escritaY) * IW'(TamanhoMalha);
  assign base      = IW'(linha_q) * IW'(TamanhoMalha);
  // Only a fresh 0->1 transition completes; a level left high from a
  // previous search must not release the grid.
  assign borda     = operacaoFinalizada && !fin_prev_q;
  assign estouro   = (tmr_q == TW'(TimeoutCiclos - 1));
  assign fim_linha = (linha_q == LW'(TamanhoMalha - 1));

  // FSM: state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado_q <= OCIOSO;
    else        estado_q <= estado_d;
  end

  // FSM: next state
  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      OCIOSO:   if (limparMalha)           estado_d = LIMPANDO;
                else if (transfer && fimLote) estado_d = DISPARO;
      LIMPANDO: if (fim_linha)             estado_d = OCIOSO;
      DISPARO:                             estado_d = AGUARDA;
      AGUARDA:  if (borda || estouro)      estado_d = OCIOSO;
      default:                             estado_d = OCIOSO;
    endcase
  end

  // FSM: outputs
  always_comb begin
    escritaPronta = (estado_q == OCIOSO) && !limparMalha;
    novoDado      = (estado_q == DISPARO);
    ocupado       = (estado_q != OCIOSO);
  end

  // Datapath next values
  always_comb begin
    malha_d    = malha_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    linha_d    = linha_q;
    tmr_d      = tmr_q;
    erro_d     = erro_q;
    desc_d     = desc_q;
    fin_prev_d = operacaoFinalizada;

    unique case (estado_q)
      OCIOSO: begin
        if (limparMalha) linha_d = '0;
        if (transfer) begin
          if (in_range)              malha_d[idx] = escritaCelula;
          else if (desc_q != 8'hFF)  desc_d = desc_q + 8'd1;
          if (fimLote) begin
            pos_x_d = posicaoX;
            pos_y_d = posicaoY;
            erro_d  = 1'b0;
          end
        end
      end
      LIMPANDO: begin
        for (int c = 0; c < TamanhoMalha; c++) malha_d[base + IW'(c)] = LIVRE;
        linha_d = linha_q + LW'(1);
      end
      DISPARO: tmr_d = '0;
      AGUARDA: begin
        tmr_d = tmr_q + TW'(1);
        // Edge beats timeout when both land in the same cycle.
        if (!borda && estouro) erro_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      malha_q    <= '0;
      pos_x_q    <= '0;
      pos_y_q    <= '0;
      linha_q    <= '0;
      tmr_q      <= '0;
      erro_q     <= 1'b0;
      desc_q     <= '0;
      fin_prev_q <= 1'b0;
    end else begin
      malha_q    <= malha_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      linha_q    <= linha_d;
      tmr_q      <= tmr_d;
      erro_q     <= erro_d;
      desc_q     <= desc_d;
      fin_prev_q <= fin_prev_d;
    end
  end

  assign malha               = malha_q;
  assign posicaoAtualnoEixoX = pos_x_q;
  assign posicaoAtualnoEixoY = pos_y_q;
  assign erroTimeout         = erro_q;
  assign descartes           = desc_q;

endmodule

// File: tb/tb_atualizador_malha.sv
module tb_atualizador_malha;
  import malha_pkg::*;

  localparam int N  = 8;
  localparam int NC = N * N;
  localparam int TO = 16;

  logic               clock = 1'b0;
  logic               reset;
  logic               escritaValida, escritaPronta, fimLote, limparMalha;
  logic [7:0]         escritaX, escritaY, posicaoX, posicaoY;
  celula_t            escritaCelula;
  logic [NC-1:0][1:0] malha;
  logic [7:0]         posicaoAtualnoEixoX, posicaoAtualnoEixoY;
  logic               novoDado, operacaoFinalizada, ocupado, erroTimeout;
  logic [7:0]         descartes;

  int total = 0;
  int bad   = 0;
  int unsigned mdl[NC];
  int unsigned desc_m = 0;

  always #5 clock = ~clock;

  atualizador_malha #(.TamanhoMalha(N), .tamanhoDistancia(8), .TimeoutCiclos(TO)) dut (
    .clock(clock), .reset(reset),
    .escritaValida(escritaValida), .escritaPronta(escritaPronta),
    .escritaX(escritaX), .escritaY(escritaY), .escritaCelula(escritaCelula),
    .fimLote(fimLote), .posicaoX(posicaoX), .posicaoY(posicaoY),
    .limparMalha(limparMalha), .malha(malha),
    .posicaoAtualnoEixoX(posicaoAtualnoEixoX), .posicaoAtualnoEixoY(posicaoAtualnoEixoY),
    .novoDado(novoDado), .operacaoFinalizada(operacaoFinalizada),
    .ocupado(ocupado), .erroTimeout(erroTimeout), .descartes(descartes)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] grid_exp();
    logic [127:0] v = '0;
    for (int i = 0; i < NC; i++) v[2*i +: 2] = mdl[i][1:0];
    return v;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One accepted transfer while idle; the model applies the grid rules.
  task automatic wr(input int unsigned x, input int unsigned y, input int unsigned c, input logic fim);
    escritaX      = x[7:0];
    escritaY      = y[7:0];
    escritaCelula = celula_t'(c[1:0]);
    fimLote       = fim;
    escritaValida = 1'b1;
    step();
    escritaValida = 1'b0;
    fimLote       = 1'b0;
    if (x < N && y < N) mdl[indice(x, y, N)] = c;
    else if (desc_m < 255) desc_m++;
  endtask

  task automatic clr_model();
    for (int i = 0; i < NC; i++) mdl[i] = 0;
    desc_m = 0;
  endtask

  initial begin
    reset = 1'b0; escritaValida = 1'b0; fimLote = 1'b0; limparMalha = 1'b0;
    escritaX = '0; escritaY = '0; escritaCelula = LIVRE;
    posicaoX = '0; posicaoY = '0; operacaoFinalizada = 1'b0;
    clr_model();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_malha", 128'(malha), grid_exp());
    chk("rst_ocupado", 128'(ocupado), 0);
    chk("rst_novo", 128'(novoDado), 0);
    chk("rst_erro", 128'(erroTimeout), 0);
    chk("rst_desc", 128'(descartes), 0);
    chk("rst_pos", 128'({posicaoAtualnoEixoX, posicaoAtualnoEixoY}), 0);
    reset = 1'b1;
    step();
    chk("idle_pronta", 128'(escritaPronta), 1);

    // 1: batch-closing write
    posicaoX = 8'd5; posicaoY = 8'd6;
    wr(2, 3, 3, 1'b1);
    chk("t1_cell26", 128'(malha[26]), 3);
    chk("t1_grid", 128'(malha), grid_exp());
    chk("t1_novo", 128'(novoDado), 1);
    chk("t1_ocupado", 128'(ocupado), 1);
    chk("t1_pos", 128'({posicaoAtualnoEixoX, posicaoAtualnoEixoY}), 128'({8'd5, 8'd6}));
    step();
    chk("t1_novo_1cyc", 128'(novoDado), 0);

    // 2: writes blocked while the search runs
    posicaoX = 8'd9; posicaoY = 8'd9;
    escritaX = 8'd1; escritaY = 8'd1; escritaCelula = OBSTACULO; escritaValida = 1'b1;
    #1;
    chk("t2_pronta0", 128'(escritaPronta), 0);
    repeat (3) step();
    chk("t2_grid_hold", 128'(malha), grid_exp());
    chk("t2_pos_hold", 128'({posicaoAtualnoEixoX, posicaoAtualnoEixoY}), 128'({8'd5, 8'd6}));
    operacaoFinalizada = 1'b1;
    step();
    chk("t2_idle", 128'(ocupado), 0);
    chk("t2_pronta1", 128'(escritaPronta), 1);
    step();
    escritaValida = 1'b0;
    mdl[indice(1, 1, N)] = 1;
    chk("t2_accept", 128'(malha), grid_exp());
    operacaoFinalizada = 1'b0;

    // 3: out-of-range writes, random mix, saturation
    wr(8, 0, 2, 1'b0);
    wr(255, 255, 2, 1'b0);
    chk("t3_grid", 128'(malha), grid_exp());
    chk("t3_desc2", 128'(descartes), 2);
    for (int k = 0; k < 150; k++)
      wr($urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 3), 1'b0);
    chk("t3_rand_grid", 128'(malha), grid_exp());
    chk("t3_rand_desc", 128'(descartes), 128'(desc_m));
    for (int k = 0; k < 300; k++)
      wr($urandom_range(8, 255), $urandom_range(0, 255), 1, 1'b0);
    chk("t3_sat", 128'(descartes), 255);
    chk("t3_sat_model", 128'(descartes), 128'(desc_m));
    chk("t3_grid2", 128'(malha), grid_exp());

    // 4: clear a full grid with a write pending
    for (int i = 0; i < NC; i++) wr(i % N, i / N, 3, 1'b0);
    chk("t4_full", 128'(malha), grid_exp());
    escritaX = 8'd0; escritaY = 8'd7; escritaCelula = OBSTACULO;
    escritaValida = 1'b1; limparMalha = 1'b1;
    #1;
    chk("t4_pronta0", 128'(escritaPronta), 0);
    step();
    limparMalha = 1'b0;
    chk("t4_busy", 128'(ocupado), 1);
    chk("t4_pronta_busy", 128'(escritaPronta), 0);
    repeat (4) step();
    for (int i = 0; i < 4 * N; i++) mdl[i] = 0;
    chk("t4_half", 128'(malha), grid_exp());
    repeat (4) step();
    escritaValida = 1'b0;
    for (int i = 0; i < NC; i++) mdl[i] = 0;
    chk("t4_clear", 128'(malha), grid_exp());
    chk("t4_idle", 128'(ocupado), 0);

    // 5: timeout with a stale high done level
    operacaoFinalizada = 1'b1;
    posicaoX = 8'd1; posicaoY = 8'd2;
    wr(0, 0, 2, 1'b1);
    step();
    repeat (TO - 1) step();
    chk("t5_still_wait", 128'({ocupado, erroTimeout}), 128'(2'b10));
    step();
    chk("t5_timeout", 128'({ocupado, erroTimeout}), 128'(2'b01));
    chk("t5_grid", 128'(malha), grid_exp());
    // edge and timeout together: edge wins
    operacaoFinalizada = 1'b0;
    wr(1, 0, 1, 1'b1);
    chk("t5_err_clr", 128'(erroTimeout), 0);
    step();
    repeat (TO - 1) step();
    operacaoFinalizada = 1'b1;
    step();
    chk("t5_edge_wins", 128'({ocupado, erroTimeout}), 128'(2'b00));
    operacaoFinalizada = 1'b0;

    // 6: reset in AGUARDA and in LIMPANDO
    posicaoX = 8'd7; posicaoY = 8'd7;
    wr(3, 3, 3, 1'b1);
    step();
    chk("t6_in_wait", 128'(ocupado), 1);
    reset = 1'b0;
    #1;
    clr_model();
    chk("t6_rst_grid", 128'(malha), grid_exp());
    chk("t6_rst_out", 128'({ocupado, novoDado, posicaoAtualnoEixoX, posicaoAtualnoEixoY}), 0);
    #10 reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_no_pulse", 128'({novoDado, ocupado}), 0);
    end
    wr(5, 5, 2, 1'b0);
    limparMalha = 1'b1;
    step();
    limparMalha = 1'b0;
    step();
    reset = 1'b0;
    #1;
    clr_model();
    chk("t6_rst_clr_grid", 128'(malha), grid_exp());
    chk("t6_rst_clr_busy", 128'(ocupado), 0);
    #10 reset = 1'b1;
    step();
    chk("t6_after", 128'({novoDado, ocupado, descartes}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
